// File: rtl/uart_rx_buf_ctrl.sv
// Receive-side buffer for a UART: show-ahead FIFO of {stop_err, parity_err, data},
// occupancy FSM, sticky overrun flag, saturating frame/error counters and parity config.
module uart_rx_buf_ctrl #(
  parameter int unsigned DEPTH    = 4,
  parameter bit          DROP_ERR = 1'b0
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [7:0]               i_rx_data,
  input  logic                     i_rx_valid,
  input  logic                     i_rx_parity_error,
  input  logic                     i_rx_stop_error,
  input  logic                     i_cfg_wr,
  input  logic                     i_cfg_parity_en,
  output logic                     o_parity_en,
  output logic [7:0]               o_rd_data,
  output logic                     o_rd_perr,
  output logic                     o_rd_serr,
  output logic                     o_rd_valid,
  input  logic                     i_rd_ready,
  output logic [$clog2(DEPTH):0]   o_level,
  output logic                     o_full,
  output logic                     o_empty,
  output logic                     o_overrun,
  input  logic                     i_clr_status,
  output logic [7:0]               o_frame_cnt,
  output logic [7:0]               o_err_cnt
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  typedef enum logic [1:0] {StIdle, StActive, StFull} state_t;

  state_t          r_state;
  logic [9:0]      r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [LW-1:0]   r_level;
  logic [LW-1:0]   w_level_nxt;
  logic            r_rd_valid;
  logic            r_overrun;
  logic            r_parity_en;
  logic [7:0]      r_frame_cnt;
  logic [7:0]      r_err_cnt;
  logic            w_full;
  logic            w_pop;
  logic            w_push;
  logic            w_err;
  logic            w_ovr_set;

  assign w_full = (r_state == StFull);
  assign w_err  = i_rx_parity_error | i_rx_stop_error;
  assign w_pop  = r_rd_valid & i_rd_ready;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign w_push    = i_rx_valid & (~w_full | w_pop) & ~(DROP_ERR & w_err);
  assign w_ovr_set = i_rx_valid & w_full & ~w_pop;

  always_comb begin
    w_level_nxt = r_level;
    if (w_push && !w_pop) begin
      w_level_nxt = r_level + LW'(1);
    end else if (!w_push && w_pop) begin
      w_level_nxt = r_level - LW'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {i_rx_stop_error, i_rx_parity_error, i_rx_data};
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= StIdle;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_level    <= w_level_nxt;
      r_rd_valid <= (w_level_nxt != '0);
      if (w_level_nxt == '0) begin
        r_state <= StIdle;
      end else if (w_level_nxt == LW'(DEPTH)) begin
        r_state <= StFull;
      end else begin
        r_state <= StActive;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_overrun   <= 1'b0;
      r_frame_cnt <= '0;
      r_err_cnt   <= '0;
      r_parity_en <= 1'b0;
    end else begin
      if (i_clr_status) begin
        r_overrun   <= 1'b0;
        r_frame_cnt <= '0;
        r_err_cnt   <= '0;
      end else begin
        if (w_ovr_set) r_overrun <= 1'b1;
        if (i_rx_valid && r_frame_cnt != 8'hFF) r_frame_cnt <= r_frame_cnt + 8'd1;
        if (i_rx_valid && w_err && r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
      end
      if (i_cfg_wr) r_parity_en <= i_cfg_parity_en;
    end
  end

  assign {o_rd_serr, o_rd_perr, o_rd_data} = r_mem[r_rd_ptr];
  assign o_rd_valid  = r_rd_valid;
  assign o_level     = r_level;
  assign o_full      = w_full;
  assign o_empty     = (r_state == StIdle);
  assign o_overrun   = r_overrun;
  assign o_frame_cnt = r_frame_cnt;
  assign o_err_cnt   = r_err_cnt;
  assign o_parity_en = r_parity_en;

endmodule

// File: tb/tb_uart_rx_buf_ctrl.sv
// Bench for uart_rx_buf_ctrl: two instances (keep / drop errored frames) checked every
// cycle against a queue-based model, plus directed literal expectations.
module tb_uart_rx_buf_ctrl;
  localparam int unsigned DEPTH = 4;

  logic       clk, rst;
  logic [7:0] rx_data;
  logic       rx_valid, rx_pe, rx_se, cfg_wr, cfg_pen, rd_ready, clr;

  logic       o0_pen, o0_rv, o0_pe, o0_se, o0_full, o0_empty, o0_ovr;
  logic [7:0] o0_rd, o0_fc, o0_ec;
  logic [2:0] o0_lvl;
  logic       o1_pen, o1_rv, o1_pe, o1_se, o1_full, o1_empty, o1_ovr;
  logic [7:0] o1_rd, o1_fc, o1_ec;
  logic [2:0] o1_lvl;

  uart_rx_buf_ctrl #(.DEPTH(DEPTH), .DROP_ERR(1'b0)) u_dut (
    .i_clk(clk), .i_rst(rst), .i_rx_data(rx_data), .i_rx_valid(rx_valid),
    .i_rx_parity_error(rx_pe), .i_rx_stop_error(rx_se), .i_cfg_wr(cfg_wr),
    .i_cfg_parity_en(cfg_pen), .o_parity_en(o0_pen), .o_rd_data(o0_rd), .o_rd_perr(o0_pe),
    .o_rd_serr(o0_se), .o_rd_valid(o0_rv), .i_rd_ready(rd_ready), .o_level(o0_lvl),
    .o_full(o0_full), .o_empty(o0_empty), .o_overrun(o0_ovr), .i_clr_status(clr),
    .o_frame_cnt(o0_fc), .o_err_cnt(o0_ec)
  );

  uart_rx_buf_ctrl #(.DEPTH(DEPTH), .DROP_ERR(1'b1)) u_dut_drop (
    .i_clk(clk), .i_rst(rst), .i_rx_data(rx_data), .i_rx_valid(rx_valid),
    .i_rx_parity_error(rx_pe), .i_rx_stop_error(rx_se), .i_cfg_wr(cfg_wr),
    .i_cfg_parity_en(cfg_pen), .o_parity_en(o1_pen), .o_rd_data(o1_rd), .o_rd_perr(o1_pe),
    .o_rd_serr(o1_se), .o_rd_valid(o1_rv), .i_rd_ready(rd_ready), .o_level(o1_lvl),
    .o_full(o1_full), .o_empty(o1_empty), .o_overrun(o1_ovr), .i_clr_status(clr),
    .o_frame_cnt(o1_fc), .o_err_cnt(o1_ec)
  );

  int checks = 0;
  int errors = 0;

  // Model state, index 0 = keep errored frames, index 1 = drop them.
  logic [9:0] mq [2][$];
  int         m_frames [2];
  int         m_errs [2];
  bit         m_ovr [2];
  bit         m_pen;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      m_frames[k] = 0;
      m_errs[k]   = 0;
      m_ovr[k]    = 1'b0;
    end
    m_pen = 1'b0;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        for (int k = 0; k < 2; k++) begin
          mq[k].delete();
          m_frames[k] = 0;
          m_errs[k]   = 0;
          m_ovr[k]    = 1'b0;
        end
        m_pen = 1'b0;
      end else begin
        for (int k = 0; k < 2; k++) begin
          bit full, pop, err;
          full = (mq[k].size() == DEPTH);
          pop  = (mq[k].size() != 0) && rd_ready;
          err  = rx_pe || rx_se;
          if (pop) void'(mq[k].pop_front());
          if (rx_valid) begin
            if (m_frames[k] < 255) m_frames[k]++;
            if (err && m_errs[k] < 255) m_errs[k]++;
            if (full && !pop) m_ovr[k] = 1'b1;
            else if (!(k == 1 && err)) mq[k].push_back({rx_se, rx_pe, rx_data});
          end
          if (clr) begin
            m_frames[k] = 0;
            m_errs[k]   = 0;
            m_ovr[k]    = 1'b0;
          end
        end
        if (cfg_wr) m_pen = cfg_pen;
      end
    end
  end

  task automatic cmp(input int k, input logic pen, input logic rv, input logic [7:0] rd,
                     input logic pe, input logic se, input logic [2:0] lvl, input logic full,
                     input logic empty, input logic ovr, input logic [7:0] fc,
                     input logic [7:0] ec);
    int sz;
    logic [9:0] ent;
    sz = mq[k].size();
    chk($sformatf("i%0d.rd_valid", k), rv, sz != 0);
    chk($sformatf("i%0d.level", k), lvl, sz);
    chk($sformatf("i%0d.full", k), full, sz == DEPTH);
    chk($sformatf("i%0d.empty", k), empty, sz == 0);
    chk($sformatf("i%0d.overrun", k), ovr, m_ovr[k]);
    chk($sformatf("i%0d.frame_cnt", k), fc, m_frames[k]);
    chk($sformatf("i%0d.err_cnt", k), ec, m_errs[k]);
    chk($sformatf("i%0d.parity_en", k), pen, m_pen);
    if (sz != 0) begin
      ent = mq[k][0];
      chk($sformatf("i%0d.rd_data", k), rd, ent[7:0]);
      chk($sformatf("i%0d.rd_perr", k), pe, ent[8]);
      chk($sformatf("i%0d.rd_serr", k), se, ent[9]);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      cmp(0, o0_pen, o0_rv, o0_rd, o0_pe, o0_se, o0_lvl, o0_full, o0_empty, o0_ovr, o0_fc, o0_ec);
      cmp(1, o1_pen, o1_rv, o1_rd, o1_pe, o1_se, o1_lvl, o1_full, o1_empty, o1_ovr, o1_fc, o1_ec);
    end
  end

  task automatic rx(input logic [7:0] d, input logic pe, input logic se, input logic rdy);
    rx_data  = d;
    rx_pe    = pe;
    rx_se    = se;
    rx_valid = 1'b1;
    rd_ready = rdy;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_pe    = 1'b0;
    rx_se    = 1'b0;
    rd_ready = 1'b0;
  endtask

  task automatic clear_status();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  task automatic drain(input int n);
    rd_ready = 1'b1;
    repeat (n) @(negedge clk);
    rd_ready = 1'b0;
  endtask

  initial begin
    logic [7:0] exp_b [4];
    rst = 1'b0; rx_data = '0; rx_valid = 1'b0; rx_pe = 1'b0; rx_se = 1'b0;
    cfg_wr = 1'b0; cfg_pen = 1'b0; rd_ready = 1'b0; clr = 1'b0;
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset.empty", o0_empty, 1'b1);
    chk("reset.full", o0_full, 1'b0);
    chk("reset.level", o0_lvl, 3'd0);
    rst = 1'b0;
    @(negedge clk);

    // Single push, show-ahead head visible next cycle.
    rx(8'hA5, 1'b0, 1'b0, 1'b0);
    chk("basic.rd_valid", o0_rv, 1'b1);
    chk("basic.rd_data", o0_rd, 8'hA5);
    chk("basic.level", o0_lvl, 3'd1);
    chk("basic.frame_cnt", o0_fc, 8'd1);
    drain(1);
    chk("basic.empty_after_pop", o0_empty, 1'b1);

    // Fill and overrun.
    clear_status();
    for (int i = 1; i <= 5; i++) rx(8'(i), 1'b0, 1'b0, 1'b0);
    chk("fill.full", o0_full, 1'b1);
    chk("fill.overrun", o0_ovr, 1'b1);
    chk("fill.frame_cnt", o0_fc, 8'd5);
    chk("fill.level", o0_lvl, 3'd4);
    for (int i = 1; i <= 4; i++) begin
      chk("fill.read", o0_rd, 8'(i));
      rd_ready = 1'b1;
      @(negedge clk);
    end
    rd_ready = 1'b0;
    chk("fill.empty", o0_empty, 1'b1);
    rd_ready = 1'b1;
    @(negedge clk);
    rd_ready = 1'b0;
    chk("empty.ready_ignored", o0_lvl, 3'd0);

    // Full with simultaneous push and pop.
    clear_status();
    for (int i = 1; i <= 4; i++) rx(8'(i), 1'b0, 1'b0, 1'b0);
    rx(8'h10, 1'b0, 1'b0, 1'b1);
    chk("fullpp.level", o0_lvl, 3'd4);
    chk("fullpp.overrun", o0_ovr, 1'b0);
    chk("fullpp.full", o0_full, 1'b1);
    exp_b[0] = 8'h02; exp_b[1] = 8'h03; exp_b[2] = 8'h04; exp_b[3] = 8'h10;
    for (int i = 0; i < 4; i++) begin
      chk("fullpp.read", o0_rd, exp_b[i]);
      rd_ready = 1'b1;
      @(negedge clk);
    end
    rd_ready = 1'b0;

    // Errored frames: kept with flags vs dropped.
    clear_status();
    rx(8'h33, 1'b1, 1'b0, 1'b0);
    chk("perr.rd_valid", o0_rv, 1'b1);
    chk("perr.rd_data", o0_rd, 8'h33);
    chk("perr.rd_perr", o0_pe, 1'b1);
    chk("perr.err_cnt", o0_ec, 8'd1);
    chk("drop.empty", o1_empty, 1'b1);
    chk("drop.err_cnt", o1_ec, 8'd1);
    drain(1);
    rx(8'h5A, 1'b0, 1'b1, 1'b0);
    chk("serr.rd_serr", o0_se, 1'b1);
    chk("serr.rd_perr", o0_pe, 1'b0);
    drain(1);

    // Saturation then clear racing an increment.
    clear_status();
    rx_valid = 1'b1; rx_pe = 1'b1; rx_data = 8'hEE; rd_ready = 1'b1;
    repeat (300) @(negedge clk);
    rx_valid = 1'b0; rx_pe = 1'b0; rd_ready = 1'b0;
    chk("sat.frame_cnt", o0_fc, 8'd255);
    chk("sat.err_cnt", o0_ec, 8'd255);
    chk("sat.drop_err_cnt", o1_ec, 8'd255);
    clr = 1'b1; rx_valid = 1'b1; rx_se = 1'b1;
    @(negedge clk);
    clr = 1'b0; rx_valid = 1'b0; rx_se = 1'b0;
    chk("clr.frame_cnt", o0_fc, 8'd0);
    chk("clr.err_cnt", o0_ec, 8'd0);
    drain(3);

    // Parity config load and hold.
    cfg_wr = 1'b1; cfg_pen = 1'b1;
    @(negedge clk);
    cfg_wr = 1'b0; cfg_pen = 1'b0;
    chk("cfg.parity_en", o0_pen, 1'b1);
    @(negedge clk);
    chk("cfg.hold", o0_pen, 1'b1);

    // Asynchronous reset mid-operation.
    for (int i = 0; i < 3; i++) rx(8'h60 + 8'(i), 1'b0, 1'b0, 1'b0);
    chk("prerst.level", o0_lvl, 3'd3);
    #2 rst = 1'b1;
    #1;
    chk("arst.level", o0_lvl, 3'd0);
    chk("arst.rd_valid", o0_rv, 1'b0);
    chk("arst.parity_en", o0_pen, 1'b0);
    chk("arst.empty", o0_empty, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    rx(8'h77, 1'b0, 1'b0, 1'b0);
    chk("postrst.rd_data", o0_rd, 8'h77);
    chk("postrst.level", o0_lvl, 3'd1);
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
